mtx_mem_responder: RTL and testbench



---
 rtl/mtx_rsp_pkg.sv | 17 +
 rtl/mtx_rsp_fifo.sv | 63 ++++++
 rtl/mtx_mem_responder.sv | 115 +++++++++++
 tb/tb_mtx_mem_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mtx_rsp_pkg.sv
// Shared definitions for the matrix-memory read responder.
//   ADDR_W      : SRAM row address width
//   DATA_W      : SRAM row (response) data width
//   rsp_state_e : issue FSM state encoding
// ST_GAP is only reachable when MTX_RSP_THROTTLE_EN is defined.
package mtx_rsp_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/mtx_rsp_fifo.sv
// Synchronous request-address FIFO for the read responder.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the queue)
//   push_i/data_i: enqueue (ignored when full)
//   pop_i        : dequeue (ignored when empty)
//   head_o       : oldest entry, valid while not empty
//   full_o       : no room for another entry
//   count_o      : current occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mtx_rsp_fifo
  import mtx_rsp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            push_i,
  input  logic [ADDR_W-1:0]               data_i,
  input  logic                            pop_i,
  output logic [ADDR_W-1:0]               head_o,
  output logic                            full_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   mem_q [FIFO_DEPTH];
  logic                empty;
  logic                push_en;
  logic                pop_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push_en && !rst_i) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mtx_mem_responder.sv
// Read responder between the matrix iteration engine and a row SRAM.
// Requests are queued in an address FIFO, issued to the SRAM one per cycle,
// tracked through the SRAM read latency and returned in order.
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_mem_rreq, i_mem_addr    : read request and row address
//   o_mem_rrdy                : request accepted this cycle when high
//   o_mem_dout, o_mem_dout_vld: read data and its one-cycle valid pulse
//   o_sram_cen, o_sram_addr   : SRAM read enable and address
//   i_sram_q                  : SRAM data, RD_LAT cycles after o_sram_cen
// Build option MTX_RSP_THROTTLE_EN: insert one idle cycle after every SRAM
// read, halving peak throughput.
module mtx_mem_responder
  import mtx_rsp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_rreq,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              o_mem_rrdy,
  output logic [DATA_W-1:0] o_mem_dout,
  output logic              o_mem_dout_vld,
  output logic              o_sram_cen,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [DATA_W-1:0] i_sram_q
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  rsp_state_e          state_q, state_d;
  logic                in_reset_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RD_LAT-1:0]   vld_sr_q, vld_sr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_vld_q, dout_vld_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic [ADDR_W-1:0]   fifo_head;
  logic [CntW-1:0]     fifo_count;
  logic [CntW-1:0]     count_next;

  mtx_rsp_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (fifo_push),
    .data_i  (i_mem_addr),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // in_reset_q keeps rrdy low while reset is held, using registered state only.
  assign o_mem_rrdy = !fifo_full && !in_reset_q;
  assign fifo_push  = i_mem_rreq && o_mem_rrdy;
  // ISSUE is only ever entered with a non-empty FIFO, so popping there is safe.
  assign fifo_pop   = (state_q == ST_ISSUE);
  assign count_next = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);

  assign o_sram_cen     = fifo_pop;
  assign o_sram_addr    = fifo_pop ? fifo_head : addr_q;
  assign o_mem_dout     = dout_q;
  assign o_mem_dout_vld = dout_vld_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (count_next != '0) state_d = ST_ISSUE;
      end
`ifdef MTX_RSP_THROTTLE_EN
      ST_ISSUE: state_d = ST_GAP;
      ST_GAP:   state_d = (count_next != '0) ? ST_ISSUE : ST_IDLE;
`else
      ST_ISSUE: state_d = (count_next != '0) ? ST_ISSUE : ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = o_sram_cen ? fifo_head : addr_q;
    vld_sr_d    = '0;
    vld_sr_d[0] = o_sram_cen;
    for (int unsigned i = 1; i < RD_LAT; i++) vld_sr_d[i] = vld_sr_q[i-1];
    // Last tracker stage marks the cycle in which i_sram_q holds the row.
    dout_vld_d  = vld_sr_q[RD_LAT-1];
    dout_d      = dout_vld_d ? i_sram_q : dout_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      in_reset_q <= 1'b1;
      addr_q     <= '0;
      vld_sr_q   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_reset_q <= 1'b0;
      addr_q     <= addr_d;
      vld_sr_q   <= vld_sr_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

endmodule

// File: tb/tb_mtx_mem_responder.sv
// Bench for mtx_mem_responder: two instances (RD_LAT=1 and RD_LAT=3) share
// one stimulus stream and are compared each cycle against a queue-based
// reference model of the responder and a behavioural SRAM per instance.
module tb_mtx_mem_responder;

  localparam int unsigned FifoDepth = 4;
  localparam int          NCyc      = 1600;
`ifdef MTX_RSP_THROTTLE_EN
  localparam bit Throttle = 1'b1;
`else
  localparam bit Throttle = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rreq;
  logic [9:0]   addr;

  logic         rrdy1, vld1, cen1, rrdy3, vld3, cen3;
  logic [255:0] dout1, dout3, sq1, sq3;
  logic [9:0]   saddr1, saddr3;
  logic [255:0] pipe3 [3];

  always #5 clk = ~clk;

  mtx_mem_responder #(.FIFO_DEPTH(FifoDepth), .RD_LAT(1)) dut_l1 (
    .i_clk(clk), .i_reset(rst), .i_mem_rreq(rreq), .i_mem_addr(addr),
    .o_mem_rrdy(rrdy1), .o_mem_dout(dout1), .o_mem_dout_vld(vld1),
    .o_sram_cen(cen1), .o_sram_addr(saddr1), .i_sram_q(sq1)
  );

  mtx_mem_responder #(.FIFO_DEPTH(FifoDepth), .RD_LAT(3)) dut_l3 (
    .i_clk(clk), .i_reset(rst), .i_mem_rreq(rreq), .i_mem_addr(addr),
    .o_mem_rrdy(rrdy3), .o_mem_dout(dout3), .o_mem_dout_vld(vld3),
    .o_sram_cen(cen3), .o_sram_addr(saddr3), .i_sram_q(sq3)
  );

  function automatic logic [255:0] row_data(input logic [9:0] a);
    logic [31:0] w;
    if (a == 10'h005) return {32{8'hA5}};
    w = (32'(a) + 32'd1) * 32'h9E37_79B1;
    return {w, ~w, w ^ 32'hFFFF_0000, w + 32'd7, w, ~w, w ^ 32'h0000_FFFF, w - 32'd3};
  endfunction

  // Behavioural SRAMs: row data appears RD_LAT cycles after a read enable,
  // random junk otherwise.
  always @(posedge clk) sq1 <= cen1 ? row_data(saddr1) : {8{$urandom}};
  always @(posedge clk) begin
    pipe3[0] <= cen3 ? row_data(saddr3) : {8{$urandom}};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign sq3 = pipe3[2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state
  logic [9:0]   q[$];
  bit           iss_v [NCyc];
  logic [9:0]   iss_a [NCyc];
  bit           rst_in [NCyc];
  logic [9:0]   addr_hold = '0;
  bit           issued_prev = 1'b0;
  bit           rst_prev = 1'b1;
  logic [255:0] dm1 = '0;
  logic [255:0] dm3 = '0;

  // A read issued in cycle i returns at i+1+lat unless a reset occurs in between.
  function automatic bit exp_vld(input int c, input int lat);
    int i;
    i = c - 1 - lat;
    if (i < 0) return 1'b0;
    if (!iss_v[i]) return 1'b0;
    for (int k = i; k < c; k++) if (rst_in[k]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    bit         exp_rdy, rst_v, rreq_v, push, issue;
    logic [9:0] addr_v, exp_saddr, burst_addr;
    int         burst_left, dens;
    burst_left = 0;
    burst_addr = '0;
    rst  = 1'b1;
    rreq = 1'b0;
    addr = '0;
    for (int c = 0; c < NCyc; c++) begin
      @(posedge clk);
      #1;
      cyc     = c;
      exp_rdy = !rst_prev && (q.size() < FifoDepth);
      rst_v   = (c < 3) || (c == 51);
      if (c == 3)  begin burst_left = 1; burst_addr = 10'h005; end
      if (c == 10) begin burst_left = 8; burst_addr = 10'h000; end
      if (c == 30) begin burst_left = 6; burst_addr = 10'h100; end
      if (c == 50) begin burst_left = 1; burst_addr = 10'h3FF; end
      rreq_v = 1'b0;
      addr_v = 10'($urandom);
      if (burst_left > 0) begin
        rreq_v = 1'b1;
        addr_v = burst_addr;
      end else if (c >= 60 && c < NCyc - 30) begin
        dens   = ((c / 100) % 3 == 0) ? 90 : (((c / 100) % 3 == 1) ? 50 : 10);
        rreq_v = ($urandom_range(0, 99) < dens);
        if ($urandom_range(0, 199) == 0) rst_v = 1'b1;
      end
      push = rreq_v && exp_rdy && !rst_v;
      if (push && burst_left > 0) begin
        burst_left--;
        burst_addr = burst_addr + 10'd1;
      end
      rst  = rst_v;
      rreq = rreq_v;
      addr = addr_v;

      @(negedge clk);
      issue     = (q.size() > 0) && (!Throttle || !issued_prev);
      exp_saddr = issue ? q[0] : addr_hold;
      iss_v[c]  = issue;
      iss_a[c]  = exp_saddr;
      rst_in[c] = rst_v;

      if (c >= 1) begin
        check("rrdy_l1", rrdy1, exp_rdy);
        check("rrdy_l3", rrdy3, exp_rdy);
        check("cen_l1", cen1, issue);
        check("cen_l3", cen3, issue);
        check("saddr_l1", saddr1, exp_saddr);
        check("saddr_l3", saddr3, exp_saddr);
        check("vld_l1", vld1, exp_vld(c, 1));
        check("vld_l3", vld3, exp_vld(c, 3));
        check("dout_l1", dout1, dm1);
        check("dout_l3", dout3, dm3);
      end

      // Clock edge of the model
      if (rst_v) begin
        q.delete();
        addr_hold   = '0;
        issued_prev = 1'b0;
        dm1         = '0;
        dm3         = '0;
      end else begin
        if (issue) begin
          addr_hold = q[0];
          void'(q.pop_front());
        end
        issued_prev = issue;
        if (push) q.push_back(addr_v);
        if (exp_vld(c + 1, 1)) dm1 = row_data(iss_a[c - 1]);
        if (exp_vld(c + 1, 3)) dm3 = row_data(iss_a[c - 3]);
      end
      rst_prev = rst_v;
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
